// File: rtl/datapath.sv
// rtl/datapath.sv - Game of Life generation engine over an N x N cell grid
module datapath #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*N-1:0] initial_seed,
  input  logic           run,
  output logic [N*N-1:0] grid_evolve
);

  localparam int P = N + 2;

  logic [N*N-1:0] state;
  logic [N*N-1:0] next_state;

  // State copied into a grid with a one-cell dead border, so every cell
  // sees eight in-range neighbours and edges need no special handling.
  logic [P*P-1:0] padded;

  for (genvar pr = 0; pr < P; pr++) begin : g_pad_row
    for (genvar pc = 0; pc < P; pc++) begin : g_pad_col
      if (pr == 0 || pr == P - 1 || pc == 0 || pc == P - 1) begin : g_border
        assign padded[pr*P + pc] = 1'b0;
      end else begin : g_inner
        assign padded[pr*P + pc] = state[(pr-1)*N + (pc-1)];
      end
    end
  end

  // Each cell's rule evaluated in parallel from the old generation only.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int C = (r + 1) * P + (c + 1);
      logic [3:0] cnt;

      // Moore-neighbourhood population count, 0..8.
      always_comb begin
        cnt = 4'(padded[C - P - 1]) + 4'(padded[C - P]) + 4'(padded[C - P + 1])
            + 4'(padded[C - 1])                         + 4'(padded[C + 1])
            + 4'(padded[C + P - 1]) + 4'(padded[C + P]) + 4'(padded[C + P + 1]);
      end

      assign next_state[r*N + c] = state[r*N + c] ? (cnt == 4'd2 || cnt == 4'd3)
                                                  : (cnt == 4'd3);
    end
  end

  // Seed load has priority over run; otherwise step or hold the generation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= initial_seed;
    end else if (run) begin
      state <= next_state;
    end
  end

  assign grid_evolve = state;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed self-checking bench for datapath
module tb_datapath;

  localparam int N = 24;
  localparam int W = N * N;

  logic         clk;
  logic         reset;
  logic [W-1:0] initial_seed;
  logic         run;
  logic [W-1:0] grid_evolve;

  int n_checks;
  int n_fails;

  datapath #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .initial_seed (initial_seed),
    .run          (run),
    .grid_evolve  (grid_evolve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] blinker_h, blinker_v, block, line3, line3_next, single, zero;

  initial begin
    n_checks = 0;
    n_fails  = 0;

    zero       = '0;
    blinker_h  = '0; blinker_h[124] = 1'b1; blinker_h[125] = 1'b1; blinker_h[126] = 1'b1;
    blinker_v  = '0; blinker_v[101] = 1'b1; blinker_v[125] = 1'b1; blinker_v[149] = 1'b1;
    block      = '0; block[0] = 1'b1; block[1] = 1'b1; block[24] = 1'b1; block[25] = 1'b1;
    line3      = '0; line3[0] = 1'b1; line3[1] = 1'b1; line3[2] = 1'b1;
    line3_next = '0; line3_next[1] = 1'b1; line3_next[25] = 1'b1;
    single     = '0; single[300] = 1'b1;

    reset = 1'b0;
    run   = 1'b0;
    initial_seed = blinker_h;
    #2;

    // Test 1: blinker oscillates with period 2; run asserted during reset is ignored.
    run = 1'b1;
    step();
    check("t1_reset_load", grid_evolve, blinker_h);
    step();
    check("t1_reset_ignores_run", grid_evolve, blinker_h);
    reset = 1'b1;
    step();
    check("t1_gen1", grid_evolve, blinker_v);
    step();
    check("t1_gen2", grid_evolve, blinker_h);

    // Test 2: corner block is a still life.
    reset = 1'b0; run = 1'b0; initial_seed = block;
    step();
    check("t2_reset", grid_evolve, block);
    reset = 1'b1; run = 1'b1;
    step();
    check("t2_gen1", grid_evolve, block);
    for (int i = 0; i < 9; i++) step();
    check("t2_gen10", grid_evolve, block);

    // Test 3: top-edge line, no wrap-around.
    reset = 1'b0; run = 1'b0; initial_seed = line3;
    step();
    reset = 1'b1; run = 1'b1;
    step();
    check("t3_gen1", grid_evolve, line3_next);
    check("t3_bit575", W'(grid_evolve[575]), W'(1'b0));
    check("t3_bit552", W'(grid_evolve[552]), W'(1'b0));
    check("t3_bit23",  W'(grid_evolve[23]),  W'(1'b0));

    // Test 4: empty grid stays empty; a lone cell dies.
    reset = 1'b0; run = 1'b0; initial_seed = zero;
    step();
    reset = 1'b1; run = 1'b1;
    step();
    step();
    check("t4_zero", grid_evolve, zero);
    reset = 1'b0; run = 1'b0; initial_seed = single;
    step();
    check("t4_single_load", grid_evolve, single);
    reset = 1'b1; run = 1'b1;
    step();
    check("t4_single_dies", grid_evolve, zero);

    // Test 5: run low holds the generation; reassert continues.
    reset = 1'b0; run = 1'b0; initial_seed = blinker_h;
    step();
    reset = 1'b1; run = 1'b1;
    step();
    check("t5_gen1", grid_evolve, blinker_v);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_hold", grid_evolve, blinker_v);
    end
    run = 1'b1;
    step();
    check("t5_gen2", grid_evolve, blinker_h);

    // Test 6: reset mid-run reloads the seed; output tracks seed while held.
    step();
    check("t6_pre_gen", grid_evolve, blinker_v);
    reset = 1'b0; initial_seed = block;
    step();
    check("t6_midrun_reload", grid_evolve, block);
    initial_seed = single;
    step();
    check("t6_track_seed", grid_evolve, single);
    initial_seed = blinker_v;
    step();
    check("t6_track_seed2", grid_evolve, blinker_v);
    reset = 1'b1;
    step();
    check("t6_after_release", grid_evolve, blinker_h);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
